// File: rtl/conv_frame_writer.sv
// conv_frame_writer: sink for the convolution pixel stream. Every pixel the
// convolution marks valid is written to a frame-buffer port at its (row, col)
// location. The bottom-up scan order is undone so that the buffer holds the
// top row first. Row/frame completion pulses and sticky fault flags are
// provided alongside the write port.
module conv_frame_writer #(
  parameter int WORD_SIZE    = 8,
  parameter int ROW_SIZE     = 540,
  parameter int IMAGE_HEIGHT = 360,
  parameter int BOTTOM_UP    = 1,
  parameter int ADDR_W       = $clog2(ROW_SIZE * IMAGE_HEIGHT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [WORD_SIZE-1:0]            pixel_in,
  input  logic [1:0]                      valid,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [WORD_SIZE-1:0]            mem_wdata,
  output logic                            busy,
  output logic                            row_done,
  output logic                            frame_done,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] row_idx,
  output logic [$clog2(ROW_SIZE)-1:0]     col_idx,
  output logic                            overflow,
  output logic                            protocol_err
);

  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int CW = $clog2(ROW_SIZE);

  // First write address of a frame: bottom row when the scan arrives bottom-up.
  localparam logic [ADDR_W-1:0] BASE_ADDR =
    ADDR_W'((BOTTOM_UP != 0) ? (IMAGE_HEIGHT - 1) * ROW_SIZE : 0);
  // Jump from the end of one stored row back to the start of the row above it.
  localparam logic [ADDR_W-1:0] ROW_BACK  = ADDR_W'(2 * ROW_SIZE - 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;     // address the next captured pixel goes to

  logic              w_pix_valid;
  logic              w_illegal;
  logic              w_last_col;
  logic              w_last_row;
  logic [ADDR_W-1:0] w_row_next_addr;

  assign w_pix_valid     = (valid == 2'd1);
  assign w_illegal       = valid[1];
  assign w_last_col      = (col_idx == LAST_COL);
  assign w_last_row      = (row_idx == LAST_ROW);
  // Incremental addressing: no multiplier, only add/subtract of constants.
  assign w_row_next_addr = (BOTTOM_UP != 0) ? (r_addr - ROW_BACK) : (r_addr + {{(ADDR_W-1){1'b0}}, 1'b1});

  // Frame-capture FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= {ADDR_W{1'b0}};
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {WORD_SIZE{1'b0}};
      busy         <= 1'b0;
      row_done     <= 1'b0;
      frame_done   <= 1'b0;
      row_idx      <= {RW{1'b0}};
      col_idx      <= {CW{1'b0}};
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      // Write strobe and completion pulses last a single cycle.
      mem_we     <= 1'b0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Pixels arriving before a frame is armed are dropped.
          if (start) begin
            r_state      <= S_CAPTURE;
            r_addr       <= BASE_ADDR;
            busy         <= 1'b1;
            row_idx      <= {RW{1'b0}};
            col_idx      <= {CW{1'b0}};
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (w_pix_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= r_addr;
            mem_wdata <= pixel_in;
            if (w_last_col) begin
              col_idx  <= {CW{1'b0}};
              row_done <= 1'b1;
              if (w_last_row) begin
                // Final pixel: the frame is complete, counters hold from here.
                frame_done <= 1'b1;
                busy       <= 1'b0;
                r_state    <= S_DONE;
              end else begin
                row_idx <= row_idx + {{(RW-1){1'b0}}, 1'b1};
                r_addr  <= w_row_next_addr;
              end
            end else begin
              col_idx <= col_idx + {{(CW-1){1'b0}}, 1'b1};
              r_addr  <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end else if (w_illegal) begin
            // Corrupt valid code: flag it and leave the frame position untouched.
            protocol_err <= 1'b1;
          end
        end
        S_DONE: begin
          // A restart takes priority over flagging a late pixel.
          if (start) begin
            r_state      <= S_CAPTURE;
            r_addr       <= BASE_ADDR;
            busy         <= 1'b1;
            row_idx      <= {RW{1'b0}};
            col_idx      <= {CW{1'b0}};
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
          end else if (w_pix_valid) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_writer.sv
// Bench for conv_frame_writer: two instances (bottom-up and top-down) share
// the same stimulus; expected write addresses come from the frame geometry.
module tb_conv_frame_writer;

  localparam int ROW = 4;
  localparam int H   = 3;
  localparam int N   = ROW * H;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pixel_in;
  logic [1:0] valid;

  logic       t_mem_we, t_busy, t_row_done, t_frame_done, t_overflow, t_protocol_err;
  logic [3:0] t_mem_addr;
  logic [7:0] t_mem_wdata;
  logic [1:0] t_row_idx, t_col_idx;

  logic       z_mem_we, z_busy, z_row_done, z_frame_done, z_overflow, z_protocol_err;
  logic [3:0] z_mem_addr;
  logic [7:0] z_mem_wdata;
  logic [1:0] z_row_idx, z_col_idx;

  int checks = 0;
  int errors = 0;

  conv_frame_writer #(.WORD_SIZE(8), .ROW_SIZE(ROW), .IMAGE_HEIGHT(H), .BOTTOM_UP(1)) u_bu (
    .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in), .valid(valid),
    .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .busy(t_busy),
    .row_done(t_row_done), .frame_done(t_frame_done), .row_idx(t_row_idx), .col_idx(t_col_idx),
    .overflow(t_overflow), .protocol_err(t_protocol_err)
  );

  conv_frame_writer #(.WORD_SIZE(8), .ROW_SIZE(ROW), .IMAGE_HEIGHT(H), .BOTTOM_UP(0)) u_td (
    .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in), .valid(valid),
    .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .busy(z_busy),
    .row_done(z_row_done), .frame_done(z_frame_done), .row_idx(z_row_idx), .col_idx(z_col_idx),
    .overflow(z_overflow), .protocol_err(z_protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Where the k-th received pixel belongs in a top-row-first buffer.
  function automatic int exp_addr(input int k, input int bu);
    int r;
    int c;
    r = k / ROW;
    c = k % ROW;
    if (bu != 0) return (H - 1 - r) * ROW + c;
    return r * ROW + c;
  endfunction

  // Present one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic st, input logic [1:0] v, input logic [7:0] px);
    start    = st;
    valid    = v;
    pixel_in = px;
    @(posedge clk);
    #1;
    start = 1'b0;
    valid = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; valid = 2'd1; pixel_in = 8'hA5;
    #1;
    checks++;
    if ({t_mem_we, t_mem_addr, t_mem_wdata, t_busy, t_row_done, t_frame_done, t_row_idx, t_col_idx, t_overflow, t_protocol_err} !== 22'd0) begin
      errors++; $display("FAIL reset_bu outputs got %h want 0", {t_mem_we, t_mem_addr, t_mem_wdata, t_busy, t_row_done, t_frame_done, t_row_idx, t_col_idx, t_overflow, t_protocol_err});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    checks++;
    if ({z_mem_we, z_mem_addr, z_mem_wdata, z_busy, z_row_done, z_frame_done, z_row_idx, z_col_idx, z_overflow, z_protocol_err} !== 22'd0) begin
      errors++; $display("FAIL reset_td outputs got %h want 0", {z_mem_we, z_mem_addr, z_mem_wdata, z_busy, z_row_done, z_frame_done, z_row_idx, z_col_idx, z_overflow, z_protocol_err});
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'd1, 8'($urandom));
      checks++;
      if ({t_mem_we, t_busy, t_col_idx} !== 4'b0000) begin
        errors++; $display("FAIL idle_ignore we/busy/col got %b want 0000", {t_mem_we, t_busy, t_col_idx});
      end
    end
  endtask

  // One whole frame of random pixels; gaps=1 inserts bubbles inside and between rows.
  task automatic test_frame(input int gaps);
    logic [7:0] px;
    logic       rd;
    logic       fd;
    int         ng;
    cycle(1'b1, 2'd1, 8'($urandom));
    checks++;
    if ({t_busy, t_mem_we, t_row_idx, t_col_idx, t_overflow, t_protocol_err} !== 8'b1000_0000) begin
      errors++; $display("FAIL frame_start busy/we/row/col/ovf/perr got %b want 10000000", {t_busy, t_mem_we, t_row_idx, t_col_idx, t_overflow, t_protocol_err});
    end
    for (int k = 0; k < N; k++) begin
      px = 8'($urandom);
      rd = ((k % ROW) == ROW - 1);
      fd = (k == N - 1);
      cycle(1'b0, 2'd1, px);
      checks++;
      if ({t_mem_we, t_mem_addr, t_mem_wdata, t_row_done, t_frame_done, t_busy} !== {1'b1, 4'(exp_addr(k, 1)), px, rd, fd, ~fd}) begin
        errors++; $display("FAIL frame_write_bu k=%0d we/addr/data/rd/fd/busy got %h want %h", k,
          {t_mem_we, t_mem_addr, t_mem_wdata, t_row_done, t_frame_done, t_busy}, {1'b1, 4'(exp_addr(k, 1)), px, rd, fd, ~fd});
      end
      checks++;
      if ({z_mem_we, z_mem_addr, z_mem_wdata, z_row_done, z_frame_done} !== {1'b1, 4'(exp_addr(k, 0)), px, rd, fd}) begin
        errors++; $display("FAIL frame_write_td k=%0d we/addr/data/rd/fd got %h want %h", k,
          {z_mem_we, z_mem_addr, z_mem_wdata, z_row_done, z_frame_done}, {1'b1, 4'(exp_addr(k, 0)), px, rd, fd});
      end
      if (k != N - 1) begin
        checks++;
        if ({t_row_idx, t_col_idx} !== {2'((k + 1) / ROW), 2'((k + 1) % ROW)}) begin
          errors++; $display("FAIL frame_counters k=%0d row/col got %b want %b", k, {t_row_idx, t_col_idx}, {2'((k + 1) / ROW), 2'((k + 1) % ROW)});
        end
      end
      ng = (gaps != 0) ? (rd ? 5 : 1) : 0;
      for (int g = 0; g < ng; g++) begin
        cycle(1'b0, 2'd0, 8'($urandom));
        checks++;
        if ({t_mem_we, t_mem_addr, t_mem_wdata, t_row_done, t_frame_done} !== {1'b0, 4'(exp_addr(k, 1)), px, 1'b0, 1'b0}) begin
          errors++; $display("FAIL gap_hold k=%0d we/addr/data/rd/fd got %h want %h", k,
            {t_mem_we, t_mem_addr, t_mem_wdata, t_row_done, t_frame_done}, {1'b0, 4'(exp_addr(k, 1)), px, 1'b0, 1'b0});
        end
      end
    end
  endtask

  task automatic test_overflow_restart();
    logic [7:0] px;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 2'd1, 8'($urandom));
      checks++;
      if ({t_mem_we, t_busy, t_overflow} !== 3'b001) begin
        errors++; $display("FAIL overflow we/busy/ovf got %b want 001", {t_mem_we, t_busy, t_overflow});
      end
    end
    cycle(1'b1, 2'd1, 8'($urandom));
    checks++;
    if ({t_mem_we, t_busy, t_overflow, t_row_idx, t_col_idx} !== 7'b0100000) begin
      errors++; $display("FAIL restart we/busy/ovf/row/col got %b want 0100000", {t_mem_we, t_busy, t_overflow, t_row_idx, t_col_idx});
    end
    px = 8'($urandom);
    cycle(1'b0, 2'd1, px);
    checks++;
    if ({t_mem_we, t_mem_addr, t_mem_wdata} !== {1'b1, 4'd8, px}) begin
      errors++; $display("FAIL restart_first_write got %h want %h", {t_mem_we, t_mem_addr, t_mem_wdata}, {1'b1, 4'd8, px});
    end
  endtask

  // Entered with one pixel of row 0 already captured.
  task automatic test_protocol_err();
    logic [7:0] px;
    cycle(1'b0, 2'd2, 8'hFF);
    checks++;
    if ({t_protocol_err, t_mem_we, t_row_idx, t_col_idx} !== 6'b10_0001) begin
      errors++; $display("FAIL perr_code2 perr/we/row/col got %b want 100001", {t_protocol_err, t_mem_we, t_row_idx, t_col_idx});
    end
    cycle(1'b0, 2'd3, 8'($urandom));
    checks++;
    if ({t_protocol_err, t_mem_we, t_col_idx} !== 4'b1001) begin
      errors++; $display("FAIL perr_code3 perr/we/col got %b want 1001", {t_protocol_err, t_mem_we, t_col_idx});
    end
    px = 8'($urandom);
    cycle(1'b0, 2'd1, px);
    checks++;
    if ({t_mem_we, t_mem_addr, t_mem_wdata, t_protocol_err, t_col_idx} !== {1'b1, 4'(exp_addr(1, 1)), px, 1'b1, 2'd2}) begin
      errors++; $display("FAIL perr_resume got %h want %h", {t_mem_we, t_mem_addr, t_mem_wdata, t_protocol_err, t_col_idx},
        {1'b1, 4'(exp_addr(1, 1)), px, 1'b1, 2'd2});
    end
  endtask

  // Entered with two pixels captured; runs to pixel 6 then pulls reset between edges.
  task automatic test_async_reset();
    logic [7:0] px;
    for (int k = 2; k < 6; k++) begin
      px = 8'($urandom);
      cycle(1'b0, 2'd1, px);
      checks++;
      if ({t_mem_we, t_mem_addr, t_mem_wdata} !== {1'b1, 4'(exp_addr(k, 1)), px}) begin
        errors++; $display("FAIL pre_reset_write k=%0d got %h want %h", k, {t_mem_we, t_mem_addr, t_mem_wdata}, {1'b1, 4'(exp_addr(k, 1)), px});
      end
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({t_mem_we, t_mem_addr, t_mem_wdata, t_busy, t_row_done, t_frame_done, t_row_idx, t_col_idx, t_overflow, t_protocol_err} !== 22'd0) begin
      errors++; $display("FAIL async_reset_bu got %h want 0", {t_mem_we, t_mem_addr, t_mem_wdata, t_busy, t_row_done, t_frame_done, t_row_idx, t_col_idx, t_overflow, t_protocol_err});
    end
    checks++;
    if ({z_mem_we, z_mem_addr, z_busy, z_row_idx, z_col_idx} !== 10'd0) begin
      errors++; $display("FAIL async_reset_td got %h want 0", {z_mem_we, z_mem_addr, z_busy, z_row_idx, z_col_idx});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'd1, 8'($urandom));
      checks++;
      if ({t_mem_we, t_busy, t_col_idx} !== 4'b0000) begin
        errors++; $display("FAIL post_reset_ignore we/busy/col got %b want 0000", {t_mem_we, t_busy, t_col_idx});
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(0);
    test_overflow_restart();
    test_protocol_err();
    test_async_reset();
    test_frame(1);
    test_overflow_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
